// File: rtl/port_word_tx.sv
// Serial word transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define PORT_WORD_TX_PARITY_EN to insert the parity bit between data and stop.
module port_word_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(DIV + 1);
    localparam int IW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PORT_WORD_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] shreg;
    logic             bit_end;
`ifdef PORT_WORD_TX_PARITY_EN
    logic             par;
`endif

    assign bit_end = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef PORT_WORD_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shreg    <= in_data;
`ifdef PORT_WORD_TX_PARITY_EN
                        par      <= ^in_data;
`endif
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        cnt      <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        // Shift register presents the next bit at bit 0.
                        cnt   <= '0;
                        idx   <= '0;
                        state <= DATA;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == IW'(WIDTH - 1)) begin
`ifdef PORT_WORD_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            idx   <= idx + IW'(1);
                            tx    <= shreg[0];
                            shreg <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef PORT_WORD_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt      <= '0;
                        state    <= IDLE;
                        tx       <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
